// File: rtl/lzc_normalizer_if.sv
// lzc_normalizer_if: valid/ready input and output channels of the left-normalizer.
interface lzc_normalizer_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_zero;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_zero
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count, out_zero
    );
endinterface

// File: rtl/lzc_normalizer.sv
// lzc_normalizer: iterative left-normalizer, shifts up to STEP bits per cycle
// and reports the total shift as the leading-zero count.
module lzc_normalizer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    lzc_normalizer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt, z, amt;
    logic [STEP-1:0]  top;
    logic             hit;
    logic             accept;
    assign top    = work[WIDTH-1 -: STEP];
    assign accept = state == IDLE && bus.in_valid;
    // Leading zeros inside the inspected top field; no hit means shift a full STEP.
    always_comb begin
        z   = '0;
        hit = 1'b0;
        for (int i = STEP - 1; i >= 0; i--)
            if (!hit && top[i]) begin
                hit = 1'b1;
                z   = CW'(STEP - 1 - i);
            end
        amt = hit ? z : CW'(STEP);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        if (accept)
            state_nx = bus.in_data == '0 ? DONE : SHIFT;
        else if (state == SHIFT && hit)
            state_nx = DONE;
        else if (state == DONE && bus.out_ready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            work          <= '0;
            cnt           <= '0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_zero  <= 1'b0;
        end else if (accept) begin
            work <= bus.in_data;
            cnt  <= '0;
            if (bus.in_data == '0) begin
                bus.out_data  <= '0;
                bus.out_count <= CW'(WIDTH);
                bus.out_zero  <= 1'b1;
            end
        end else if (state == SHIFT) begin
            work <= work << amt;
            cnt  <= cnt + amt;
            if (hit) begin
                bus.out_data  <= work << amt;
                bus.out_count <= cnt + amt;
                bus.out_zero  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_lzc_normalizer.sv
// tb_lzc_normalizer: scoreboard bench; driver pushes model results, monitor pops
// and compares whenever the normalizer presents a result.
module tb_lzc_normalizer;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int CW    = 6;
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    c;
        logic             z;
        int               lat;
        int               acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   ready_mode = 2;
    exp_t q[$];
    lzc_normalizer_if #(.WIDTH(WIDTH)) bus ();
    lzc_normalizer #(.WIDTH(WIDTH), .STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction
    function automatic int lead_zeros(logic [WIDTH-1:0] d);
        int n = 0;
        while (n < WIDTH && d[WIDTH-1-n] == 1'b0) n++;
        return n;
    endfunction
    task automatic send(input logic [WIDTH-1:0] d);
        exp_t e;
        int   l;
        int   k = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        l     = lead_zeros(d);
        e.d   = d << l;
        e.c   = CW'(l);
        e.z   = d == '0;
        e.lat = d == '0 ? 1 : l / STEP + 2;
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || bus.out_valid) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = ready_mode == 2 ? 1'b1 :
                               ready_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end
    // Monitor: every valid cycle must show the head-of-queue result unchanged.
    initial begin
        bit prev_valid = 0;
        bit post_hs = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_valid = 0;
                post_hs = 0;
                continue;
            end
            if (post_hs) begin
                chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
                chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
                post_hs = 0;
            end
            if (bus.out_valid) begin
                chk("in_ready_while_valid", 64'(bus.in_ready), 64'd0);
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.out_data), 64'd0 - 64'd1);
                end else begin
                    e = q[0];
                    // The cycle right after the accept edge counts as cycle 1.
                    if (!prev_valid) chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                    chk("result", {bus.out_data, bus.out_count, bus.out_zero}, {e.d, e.c, e.z});
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        post_hs = 1;
                    end
                end
            end
            prev_valid = bus.out_valid && !bus.out_ready;
        end
    end
    initial begin
        logic [WIDTH-1:0] d;
        int k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", {bus.out_data, bus.out_count, bus.out_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 2;
        send(32'h8000_0000);
        send(32'h0000_0001);
        send(32'h0001_2345);
        send(32'h0000_0000);
        drain();
        ready_mode = 1;
        send(32'h00F0_0000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0F00;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid_timeout", 64'(bus.out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        ready_mode = 2;
        send(32'h0000_0F00);
        drain();
        send(32'h0000_0001);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_outputs", {bus.out_data, bus.out_count, bus.out_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(32'h4000_0000);
        drain();
        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            d = d >> $urandom_range(0, WIDTH);
            send(d);
        end
        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/lzc_normalizer.md
# lzc_normalizer

Sequential left-normalizer that consumes an unsigned word and produces the word shifted left until its MSB is 1, together with the shift amount, i.e. the leading-zero count. It is the consumer-side counterpart of the combinational leading-zero counter. It applies the count rather than merely computing it, so downstream logic in the peripheral datapath receives a normalized value. The shifting is iterative, a bounded number of bit positions per cycle, so timing stays short. Input and output each use a valid/ready handshake.

## Interface
- WIDTH, 32: data word width; must be ≥ 2.
- STEP, 4: maximum bit positions shifted per cycle; 1 ≤ STEP ≤ WIDTH.
- CW, $clog2(WIDTH+1): width of the count output (derived; do not override).

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  unsigned word to normalize.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  normalized word, with MSB = 1 unless out_zero is set.
- out_count  output  CW  leading-zero count, equal to the total left shift applied.
- out_zero  output  1  input was all zeros.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the work register from in_data and clear the count.
  - If in_data == 0: set out_data = 0, out_count = WIDTH, out_zero = 1, and go to DONE.
  - Otherwise set out_zero = 0 and go to SHIFT.
- SHIFT (once per cycle), inspecting the top STEP bits of the work register:
  - All zero: shift left by STEP, add STEP to count, stay in SHIFT.
  - Otherwise: let z be the number of leading zeros within those STEP bits (0..STEP-1). Shift left by z, add z to count, go to DONE.
  - A nonzero word never over-shifts: some set bit always lies below an all-zero top field.
- DONE:
  - out_valid = 1.
  - out_data, out_count and out_zero are held stable until out_valid & out_ready.
  - On that handshake, go to IDLE.
- Only one word is in flight at a time. in_ready = 0 in SHIFT and DONE, so input and output never overlap.
- Arithmetic:
  - Shifts fill with zeros.
  - The count never exceeds WIDTH, so it never wraps in CW bits.
  - Final result: out_data = in_data << out_count, truncated to WIDTH bits.
- Reset (asserted at any time, including mid-SHIFT or in DONE with out_ready low):
  - Forces IDLE immediately and aborts the word in flight.
  - Reset values: out_valid = 0, out_data = 0, out_count = 0, out_zero = 0, in_ready = 1 (IDLE).
- Outputs are registered. out_data, out_count and out_zero hold their last value after the output handshake until the next result is loaded.

## Timing
- Accept edge: the edge on which in_valid & in_ready are both high, called edge A.
- Nonzero input with leading-zero count L:
  - SHIFT occupies floor(L/STEP)+1 cycles.
  - out_valid rises floor(L/STEP)+2 cycles after edge A.
- Zero input: out_valid rises 1 cycle after edge A.
- Output handshake on edge H: out_valid = 0 and in_ready = 1 in the cycle after H. The earliest next accept is the edge after H.
- Throughput with out_ready held high: one word per (floor(L/STEP)+3) cycles for nonzero input, one word per 2 cycles for zero input.
- in_valid and in_data are ignored outside IDLE.
- out_ready is ignored outside DONE.

## Test plan
- Input 0x8000_0000 (WIDTH 32, STEP 4): out_valid 2 cycles after accept, out_data 0x8000_0000, out_count 0, out_zero 0.
- Input 0x0000_0001: 8 SHIFT cycles, out_valid 9 cycles after accept, out_data 0x8000_0000, out_count 31.
- Input 0x0001_2345: out_valid 5 cycles after accept, out_data 0x91A2_8000, out_count 15.
- Input 0x0000_0000: out_valid 1 cycle after accept, out_data 0, out_count 32, out_zero 1.
- Backpressure: input 0x00F0_0000 (out_count 8, out_data 0xF000_0000), out_ready held low 5 cycles. Outputs stay stable, in_ready stays 0, and a second in_valid is not accepted. Raise out_ready: in_ready = 1 the next cycle, then the second word completes correctly.
- Reset mid-SHIFT: input 0x0000_0001, drop rst_n in the 3rd SHIFT cycle. Outputs go to reset values immediately and in_ready = 1. After release, input 0x4000_0000 yields out_count 1, out_data 0x8000_0000.
